// File: rtl/i2c_responder_pkg.sv
// Shared types and constants for the I2C/SCCB write responder.
package i2c_responder_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StReg,
        StRegAck,
        StData,
        StDataAck,
        StIgnore,
        StRd,
        StRdAck
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEF_DEV_ADDR = 7'h21;

endpackage

// File: rtl/i2c_responder_if.sv
// Bus-side and register-side signals of the responder.
// Optional macro I2C_RESP_READ_EN adds the rd_data input.
interface i2c_responder_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic       busy;
    logic [3:0] bit_count;
`ifdef I2C_RESP_READ_EN
    logic [7:0] rd_data;
`endif

    modport slave (
`ifdef I2C_RESP_READ_EN
        input  rd_data,
`endif
        input  scl_in, sda_in,
        output sda_oe, reg_addr, wr_data, wr_stb, busy, bit_count
    );

    modport master (
`ifdef I2C_RESP_READ_EN
        output rd_data,
`endif
        output scl_in, sda_in,
        input  sda_oe, reg_addr, wr_data, wr_stb, busy, bit_count
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// scl/sda synchroniser with START/STOP and scl edge pulse detection.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // Synchroniser chain plus one edge-detect stage; resets to idle-high bus.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    // START/STOP need scl stable high across the sda transition.
    always_comb begin
        sda_o      = sda_s;
        start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        scl_rise_o = scl_s & ~scl_prev_q;
        scl_fall_o = ~scl_s & scl_prev_q;
    end
endmodule

// File: rtl/i2c_responder.sv
// I2C/SCCB responder for 3-byte register writes (dev addr, reg addr, data).
// Optional macro I2C_RESP_READ_EN adds register reads via rd_data.
module i2c_responder
    import i2c_responder_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = DEF_DEV_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic            meg25,
    input logic            rst,
    i2c_responder_if.slave bus
);
    logic sda_s, start_p, stop_p, scl_rise, scl_fall;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i      (meg25),
        .rst_i      (rst),
        .scl_i      (bus.scl_in),
        .sda_i      (bus.sda_in),
        .sda_o      (sda_s),
        .start_o    (start_p),
        .stop_o     (stop_p),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall)
    );

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d, reg_addr_q, reg_addr_d, wr_data_q, wr_data_d;
    logic [3:0] bit_count_q, bit_count_d;
    logic       sda_oe_q, sda_oe_d, wr_stb_q, wr_stb_d, busy_q, busy_d;
    // In x_ACK states: ACK is being driven. In RD_ACK: master ACK seen.
    logic       phase_q, phase_d;
    logic [7:0] byte_nxt;
`ifdef I2C_RESP_READ_EN
    logic       rd_q, rd_d;
    logic [7:0] tx_q, tx_d;
`endif

    assign byte_nxt = {shift_q[6:0], sda_s};

    // State and output registers.
    always_ff @(posedge meg25 or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
            bit_count_q <= '0;
            sda_oe_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            busy_q      <= 1'b0;
            phase_q     <= 1'b0;
`ifdef I2C_RESP_READ_EN
            rd_q        <= 1'b0;
            tx_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
            bit_count_q <= bit_count_d;
            sda_oe_q    <= sda_oe_d;
            wr_stb_q    <= wr_stb_d;
            busy_q      <= busy_d;
            phase_q     <= phase_d;
`ifdef I2C_RESP_READ_EN
            rd_q        <= rd_d;
            tx_q        <= tx_d;
`endif
        end
    end

    // Next-state logic: bus conditions first, then per-state bit handling.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        bit_count_d = bit_count_q;
        sda_oe_d    = sda_oe_q;
        wr_stb_d    = 1'b0;
        busy_d      = busy_q;
        phase_d     = phase_q;
`ifdef I2C_RESP_READ_EN
        rd_d        = rd_q;
        tx_d        = tx_q;
`endif
        if (start_p) begin
            state_d     = StAddr;
            busy_d      = 1'b1;
            bit_count_d = '0;
            sda_oe_d    = 1'b0;
            phase_d     = 1'b0;
        end else if (stop_p) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            bit_count_d = '0;
            sda_oe_d    = 1'b0;
            phase_d     = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StReg, StData: begin
                    if (scl_rise) begin
                        shift_d     = byte_nxt;
                        bit_count_d = bit_count_q + 4'd1;
                        if (bit_count_q == 4'd7) begin
                            if (state_q == StAddr) begin
`ifdef I2C_RESP_READ_EN
                                rd_d = byte_nxt[0];
                                if (byte_nxt[7:1] == DEV_ADDR) begin
`else
                                if (byte_nxt[7:1] == DEV_ADDR && !byte_nxt[0]) begin
`endif
                                    state_d = StAddrAck;
                                end else begin
                                    state_d     = StIgnore;
                                    bit_count_d = '0;
                                end
                            end else if (state_q == StReg) begin
                                reg_addr_d = byte_nxt;
                                state_d    = StRegAck;
                            end else begin
                                wr_data_d = byte_nxt;
                                wr_stb_d  = 1'b1;
                                state_d   = StDataAck;
                            end
                        end
                    end
                end
                StAddrAck, StRegAck, StDataAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_oe_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            sda_oe_d    = 1'b0;
                            phase_d     = 1'b0;
                            bit_count_d = '0;
                            if (state_q == StAddrAck) begin
                                state_d = StReg;
`ifdef I2C_RESP_READ_EN
                                if (rd_q) begin
                                    // First read bit goes out on the same fall.
                                    state_d  = StRd;
                                    sda_oe_d = ~bus.rd_data[7];
                                    tx_d     = {bus.rd_data[6:0], 1'b0};
                                end
`endif
                            end else begin
                                state_d = StData;
                                if (state_q == StDataAck) begin
                                    reg_addr_d = reg_addr_q + 8'd1;
                                end
                            end
                        end
                    end
                end
`ifdef I2C_RESP_READ_EN
                StRd: begin
                    if (scl_fall) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_count_d = bit_count_q + 4'd1;
                        if (bit_count_q == 4'd7) begin
                            state_d = StRdAck;
                            phase_d = 1'b0;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_fall && !phase_q) begin
                        sda_oe_d = 1'b0;
                    end
                    if (scl_rise) begin
                        if (sda_s == ACK) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            phase_d    = 1'b1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                    if (scl_fall && phase_q) begin
                        state_d     = StRd;
                        phase_d     = 1'b0;
                        bit_count_d = '0;
                        sda_oe_d    = ~bus.rd_data[7];
                        tx_d        = {bus.rd_data[6:0], 1'b0};
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_stb    = wr_stb_q;
    assign bus.busy      = busy_q;
    assign bus.bit_count = bit_count_q;
endmodule

// File: tb/tb_i2c_responder.sv
// Self-checking bench: behavioural I2C master with open-drain pull-up model,
// table-driven directed transactions, hand-written corner cases and a random phase.
module tb_i2c_responder;
    localparam int Q = 20;  // quarter scl period in time units (10 meg25 cycles)

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } stb_t;

    typedef struct {
        logic [4:0][7:0] bytes;
        int              len;
        logic [4:0]      acks;
        int              n_stb;
        stb_t            first;
        stb_t            last;
        logic [7:0]      reg_after;
    } vec_t;

    logic meg25 = 1'b0;
    logic rst   = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   oe_cycles = 0;
    stb_t got_q[$];
    stb_t exp_q[$];
    vec_t vecs[7];

    i2c_responder_if bus();

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;  // wired-AND with pull-up
`ifdef I2C_RESP_READ_EN
    logic [7:0] rd_val = 8'hA5;
    assign bus.rd_data = rd_val;
`endif

    i2c_responder #(
        .DEV_ADDR    (7'h21),
        .SYNC_STAGES (2)
    ) dut (
        .meg25 (meg25),
        .rst   (rst),
        .bus   (bus)
    );

    always #1 meg25 = ~meg25;

    always @(negedge meg25) begin
        if (bus.wr_stb) got_q.push_back({bus.reg_addr, bus.wr_data});
        if (bus.sda_oe) oe_cycles++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_c();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic stop_c();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) begin
            sda_m = b[i]; #Q;
            scl_m = 1'b1; #(2 * Q);
            scl_m = 1'b0; #Q;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        ack = ~bus.sda_in;
        #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic run_txn(input logic [4:0][7:0] bytes, input int len, output logic [4:0] acks);
        logic a;
        acks = '0;
        got_q.delete();
        oe_cycles = 0;
        start_c();
        for (int i = 0; i < len; i++) begin
            send_byte(bytes[i], a);
            acks[i] = a;
        end
        stop_c();
    endtask

`ifdef I2C_RESP_READ_EN
    task automatic recv_byte(input logic nack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl_m = 1'b1;
            #Q; b[i] = bus.sda_in;
            #Q; scl_m = 1'b0;
            #Q;
        end
        sda_m = nack; #Q;
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #Q;
        sda_m = 1'b1;
    endtask
`endif

    initial begin
        logic [4:0]      acks;
        logic [4:0][7:0] bytes;
        logic [4:0]      exp_acks;
        logic            a;
        logic [7:0]      model_reg;
        int              len;

        // Expected results derived by hand from the protocol rules.
        vecs[0] = '{40'h00_00_80_12_42, 3, 5'b00111, 1, 16'h1280, 16'h1280, 8'h13};
        vecs[1] = '{40'h00_00_55_AA_60, 3, 5'b00000, 0, 16'h0000, 16'h0000, 8'h13};
        vecs[2] = '{40'h00_22_11_FF_42, 4, 5'b01111, 2, 16'hFF11, 16'h0022, 8'h01};
        vecs[3] = '{40'h00_00_00_3C_42, 2, 5'b00011, 0, 16'h0000, 16'h0000, 8'h3C};
        vecs[4] = '{40'h00_00_02_01_84, 3, 5'b00000, 0, 16'h0000, 16'h0000, 8'h3C};
        vecs[5] = '{40'h00_00_00_00_42, 1, 5'b00001, 0, 16'h0000, 16'h0000, 8'h3C};
`ifdef I2C_RESP_READ_EN
        vecs[6] = '{40'h00_00_00_00_20, 1, 5'b00000, 0, 16'h0000, 16'h0000, 8'h3C};
`else
        vecs[6] = '{40'h00_00_00_33_43, 2, 5'b00000, 0, 16'h0000, 16'h0000, 8'h3C};
`endif

        #10;
        check("rst_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_reg_addr", 32'(bus.reg_addr), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_wr_stb", 32'(bus.wr_stb), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_bit_count", 32'(bus.bit_count), 0);
        rst = 1'b0;
        #20;

        // Directed transaction table.
        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].bytes, vecs[v].len, acks);
            check($sformatf("vec%0d_acks", v), 32'(acks), 32'(vecs[v].acks));
            check($sformatf("vec%0d_nstb", v), got_q.size(), vecs[v].n_stb);
            if (vecs[v].n_stb > 0 && got_q.size() > 0) begin
                check($sformatf("vec%0d_first", v), 32'(got_q[0]), 32'(vecs[v].first));
                check($sformatf("vec%0d_last", v), 32'(got_q[got_q.size()-1]),
                      32'(vecs[v].last));
            end
            check($sformatf("vec%0d_reg", v), 32'(bus.reg_addr), 32'(vecs[v].reg_after));
            check($sformatf("vec%0d_busy", v), 32'(bus.busy), 0);
            if (vecs[v].acks == 0) check($sformatf("vec%0d_oe", v), oe_cycles, 0);
        end

        // Repeated START after the register byte.
        got_q.delete();
        start_c();
        check("rs_busy_start", 32'(bus.busy), 1);
        send_byte(8'h42, a);
        check("rs_ack0", 32'(a), 1);
        send_byte(8'h05, a);
        start_c();
        check("rs_bitcnt", 32'(bus.bit_count), 0);
        send_byte(8'h42, a);
        send_byte(8'h07, a);
        send_byte(8'h33, a);
        check("rs_ack_data", 32'(a), 1);
        stop_c();
        check("rs_nstb", got_q.size(), 1);
        if (got_q.size() == 1) check("rs_stb", 32'(got_q[0]), 32'h0733);

        // Reset in the middle of a data byte.
        got_q.delete();
        start_c();
        send_byte(8'h42, a);
        send_byte(8'h10, a);
        send_bits(8'hC3, 4);
        check("mid_bitcnt", 32'(bus.bit_count), 4);
        rst = 1'b1; #2;
        check("mid_rst_oe", 32'(bus.sda_oe), 0);
        #4; rst = 1'b0; #10;
        check("mid_rst_busy", 32'(bus.busy), 0);

        // Reset while the ACK is being driven must release sda at once.
        start_c();
        send_bits(8'h42, 8);
        sda_m = 1'b1; #Q;
        check("ack_driven", 32'(bus.sda_oe), 1);
        rst = 1'b1; #2;
        check("ack_rst_oe", 32'(bus.sda_oe), 0);
        #4; rst = 1'b0; #10;
        check("rst_nstb", got_q.size(), 0);
        stop_c();
        run_txn(40'h00_00_99_20_42, 3, acks);
        check("post_rst_acks", 32'(acks), 32'h7);
        check("post_rst_nstb", got_q.size(), 1);
        if (got_q.size() == 1) check("post_rst_stb", 32'(got_q[0]), 32'h2099);

`ifdef I2C_RESP_READ_EN
        // Register read with a final NACK.
        rd_val = 8'hA5;
        start_c();
        send_byte(8'h42, a);
        send_byte(8'h10, a);
        start_c();
        send_byte(8'h43, a);
        check("rd_addr_ack", 32'(a), 1);
        begin
            logic [7:0] rb;
            recv_byte(1'b1, rb);
            check("rd_byte", 32'(rb), 32'hA5);
        end
        #Q;
        check("rd_released", 32'(bus.sda_oe), 0);
        check("rd_reg_nack", 32'(bus.reg_addr), 32'h10);
        stop_c();
`endif

        // Random transactions against a byte-level protocol model.
        rst = 1'b1; #4; rst = 1'b0; #10;
        model_reg = 8'h00;
        for (int t = 0; t < 15; t++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) bytes[0] = 8'h42;
`ifdef I2C_RESP_READ_EN
            if (bytes[0] == 8'h43) bytes[0] = 8'h44;
`endif
            exp_q.delete();
            exp_acks = '0;
            if (bytes[0] == 8'h42) begin
                for (int i = 0; i < len; i++) exp_acks[i] = 1'b1;
                if (len >= 2) begin
                    model_reg = bytes[1];
                    for (int i = 2; i < len; i++) begin
                        exp_q.push_back({model_reg, bytes[i]});
                        model_reg = model_reg + 8'd1;
                    end
                end
            end
            run_txn(bytes, len, acks);
            check($sformatf("rnd%0d_acks", t), 32'(acks), 32'(exp_acks));
            check($sformatf("rnd%0d_nstb", t), got_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check($sformatf("rnd%0d_stb%0d", t, i), 32'(got_q[i]), 32'(exp_q[i]));
            check($sformatf("rnd%0d_reg", t), 32'(bus.reg_addr), 32'(model_reg));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
